// File: rtl/cdr_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cdr_loop_ctrl
//  Description : CDR fractional-divider loop controller. Collects phase
//                detector early/late votes over fixed windows, raises a
//                held adjust request (o_T / o_E) until acknowledged, applies
//                a post-adjust settle interval and reports loop lock.
//                Optional feature macro: CDR_LOOP_STATS_EN (adjust counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdr_loop_ctrl #(
  parameter int WIN      = 16,
  parameter int THRESH   = 4,
  parameter int HOLDOFF  = 4,
  parameter int LOCK_WIN = 3,
  parameter int ACK_TO   = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_restart,
  input  logic       i_pd_valid,
  input  logic       i_pd_early,
  input  logic       i_pd_late,
  input  logic       i_adj_ack,
  output logic       o_T,
  output logic       o_E,
  output logic       o_locked,
  output logic       o_err,
`ifdef CDR_LOOP_STATS_EN
  output logic [7:0] o_nb_adj_early,
  output logic [7:0] o_nb_adj_late,
`endif
  output logic [2:0] o_state
);

  localparam int CW  = $clog2(WIN + 1);
  localparam int CWX = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ     = 3'd1,
    S_DECIDE  = 3'd2,
    S_ADJUST  = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] smp_cnt_q, smp_cnt_d;
  logic [CW-1:0] early_cnt_q, early_cnt_d;
  logic [CW-1:0] late_cnt_q, late_cnt_d;
  logic [7:0]    ho_cnt_q, ho_cnt_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic          t_q, t_d;
  logic          e_q, e_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  // Votes are compared one bit wider so that cnt + THRESH cannot wrap.
  logic          vote_late, vote_early;
  assign vote_late  = {1'b0, late_cnt_q}  >= ({1'b0, early_cnt_q} + CWX'(THRESH));
  assign vote_early = {1'b0, early_cnt_q} >= ({1'b0, late_cnt_q}  + CWX'(THRESH));

  // Next-state and output decode; enable and restart override the FSM.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    early_cnt_d = early_cnt_q;
    late_cnt_d  = late_cnt_q;
    ho_cnt_d    = ho_cnt_q;
    to_cnt_d    = to_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    t_d         = t_q;
    e_d         = e_q;
    locked_d    = locked_q;
    err_d       = 1'b0;

    if (!i_en) begin
      state_d     = S_IDLE;
      smp_cnt_d   = '0;
      early_cnt_d = '0;
      late_cnt_d  = '0;
      ho_cnt_d    = '0;
      to_cnt_d    = '0;
      lock_cnt_d  = '0;
      t_d         = 1'b0;
      e_d         = 1'b0;
      locked_d    = 1'b0;
    end else if (i_restart) begin
      state_d     = S_ACQ;
      smp_cnt_d   = '0;
      early_cnt_d = '0;
      late_cnt_d  = '0;
      ho_cnt_d    = '0;
      to_cnt_d    = '0;
      lock_cnt_d  = '0;
      t_d         = 1'b0;
      e_d         = 1'b0;
      locked_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_ACQ;
          smp_cnt_d   = '0;
          early_cnt_d = '0;
          late_cnt_d  = '0;
        end
        S_ACQ: begin
          if (i_pd_valid) begin
            smp_cnt_d = smp_cnt_q + CW'(1);
            if (i_pd_early && !i_pd_late) early_cnt_d = early_cnt_q + CW'(1);
            if (i_pd_late && !i_pd_early) late_cnt_d = late_cnt_q + CW'(1);
            if (smp_cnt_q == CW'(WIN - 1)) state_d = S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (vote_late || vote_early) begin
            state_d    = S_ADJUST;
            t_d        = 1'b1;
            e_d        = vote_late;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            to_cnt_d   = '0;
          end else begin
            state_d     = S_ACQ;
            smp_cnt_d   = '0;
            early_cnt_d = '0;
            late_cnt_d  = '0;
            if (lock_cnt_q != 4'(LOCK_WIN)) lock_cnt_d = lock_cnt_q + 4'd1;
            locked_d = (lock_cnt_d == 4'(LOCK_WIN));
          end
        end
        S_ADJUST: begin
          // Ack takes precedence over a timeout landing on the same edge.
          if (i_adj_ack) begin
            t_d = 1'b0;
            e_d = 1'b0;
            if (HOLDOFF == 0) begin
              state_d     = S_ACQ;
              smp_cnt_d   = '0;
              early_cnt_d = '0;
              late_cnt_d  = '0;
            end else begin
              state_d  = S_HOLDOFF;
              ho_cnt_d = '0;
            end
          end else if (to_cnt_q == 8'(ACK_TO - 1)) begin
            t_d         = 1'b0;
            e_d         = 1'b0;
            err_d       = 1'b1;
            state_d     = S_ACQ;
            smp_cnt_d   = '0;
            early_cnt_d = '0;
            late_cnt_d  = '0;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
        S_HOLDOFF: begin
          if (i_pd_valid) begin
            if (ho_cnt_q == 8'(HOLDOFF - 1)) begin
              state_d     = S_ACQ;
              smp_cnt_d   = '0;
              early_cnt_d = '0;
              late_cnt_d  = '0;
            end else begin
              ho_cnt_d = ho_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      smp_cnt_q   <= '0;
      early_cnt_q <= '0;
      late_cnt_q  <= '0;
      ho_cnt_q    <= '0;
      to_cnt_q    <= '0;
      lock_cnt_q  <= '0;
      t_q         <= 1'b0;
      e_q         <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      early_cnt_q <= early_cnt_d;
      late_cnt_q  <= late_cnt_d;
      ho_cnt_q    <= ho_cnt_d;
      to_cnt_q    <= to_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      t_q         <= t_d;
      e_q         <= e_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign o_T      = t_q;
  assign o_E      = e_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;
  assign o_state  = state_q;

`ifdef CDR_LOOP_STATS_EN
  logic [7:0] nb_early_q, nb_early_d;
  logic [7:0] nb_late_q, nb_late_d;
  logic       adj_entry;

  assign adj_entry = (state_q == S_DECIDE) && (state_d == S_ADJUST);

  // Saturating per-direction adjust counters; only the hard reset clears them.
  always_comb begin
    nb_early_d = nb_early_q;
    nb_late_d  = nb_late_q;
    if (adj_entry && !e_d && (nb_early_q != 8'hFF)) nb_early_d = nb_early_q + 8'd1;
    if (adj_entry && e_d && (nb_late_q != 8'hFF))   nb_late_d  = nb_late_q + 8'd1;
  end

  // Adjust statistics registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nb_early_q <= '0;
      nb_late_q  <= '0;
    end else begin
      nb_early_q <= nb_early_d;
      nb_late_q  <= nb_late_d;
    end
  end

  assign o_nb_adj_early = nb_early_q;
  assign o_nb_adj_late  = nb_late_q;
`endif

endmodule
`default_nettype wire

// File: doc/cdr_loop_ctrl.md
# cdr_loop_ctrl

Loop controller for the CDR fractional divider. Collects early/late votes from the phase detector over fixed windows, decides whether the sampling period must be shortened or lengthened, and issues a single adjust request (`o_T`/`o_E`) held until the divider acknowledges it on its frequency-synch enable. Also applies a post-adjust settle interval and reports loop lock to the demodulator control.

## Interface

Parameters:
- `WIN`, 16: valid phase-detector samples per voting window (2..255).
- `THRESH`, 4: minimum vote difference that triggers an adjust (1..WIN).
- `HOLDOFF`, 4: valid samples discarded after an acknowledged adjust (0..255).
- `LOCK_WIN`, 3: consecutive no-adjust windows required to assert lock (1..15).
- `ACK_TO`, 255: cycles in ADJUST without ack before abort (1..255).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  system clock (50 MHz).
- `i_rst`  in  1  asynchronous active-low reset.
- `i_en`  in  1  loop enable; 0 forces IDLE.
- `i_restart`  in  1  synchronous restart pulse (new chip/packet phase).
- `i_pd_valid`  in  1  phase-detector sample strobe.
- `i_pd_early`  in  1  early vote, qualified by `i_pd_valid`.
- `i_pd_late`  in  1  late vote, qualified by `i_pd_valid`.
- `i_adj_ack`  in  1  divider frequency-synch enable; acknowledges `o_T`.
- `o_T`  out  1  adjust request, level, held until ack/abort.
- `o_E`  out  1  direction: 1 = lengthen period (+2), 0 = shorten (−2); valid while `o_T`=1.
- `o_locked`  out  1  loop lock flag.
- `o_err`  out  1  one-cycle pulse on ack timeout.
- `o_state`  out  3  FSM state code (debug).

## Operation

- States (code): IDLE 0, ACQ 1, DECIDE 2, ADJUST 3, HOLDOFF 4.
- Vote counters `early_cnt`, `late_cnt`, `smp_cnt`: width $clog2(WIN+1), unsigned, cleared on every ACQ entry.
- IDLE: all outputs at reset values; `i_en`=1 → ACQ.
- ACQ: each `i_pd_valid` increments `smp_cnt`; early-only increments `early_cnt`; late-only increments `late_cnt`; both or neither: sample counted, no vote. When the WIN-th valid sample is registered → DECIDE.
- DECIDE (one cycle): `late_cnt` ≥ `early_cnt`+THRESH → `o_T`=1, `o_E`=1, lock counter and `o_locked` cleared, → ADJUST. `early_cnt` ≥ `late_cnt`+THRESH → `o_T`=1, `o_E`=0, lock cleared, → ADJUST. Otherwise lock counter increments (saturates at LOCK_WIN), `o_locked`=1 when it equals LOCK_WIN, → ACQ. Comparisons are done one bit wider than the counters, no wrap.
- ADJUST: `o_T`/`o_E` held. `i_adj_ack`=1 → `o_T`=0, → HOLDOFF (or ACQ if HOLDOFF=0). Timeout counter reaching ACK_TO → `o_T`=0, `o_err`=1 for one cycle, → ACQ. Ack and timeout in the same cycle: ack wins, no `o_err`.
- HOLDOFF: counts HOLDOFF valid samples, votes ignored, then → ACQ.
- `i_ack` outside ADJUST is ignored.
- Priority per cycle: `i_rst` > `i_en`=0 (→ IDLE, lock cleared, `o_T` dropped) > `i_restart` (→ ACQ, counters and lock cleared, `o_T` dropped, no `o_err`) > normal FSM.

## Timing

- Reset (asynchronous): state IDLE, `o_T`=0, `o_E`=0, `o_locked`=0, `o_err`=0, all counters 0. Reset mid-ADJUST drops `o_T` immediately.
- All outputs registered on the `i_clk` rising edge.
- Last window sample at edge k → DECIDE at k; `o_T` high from edge k+1.
- Ack sampled at edge m → `o_T` low after edge m. Minimum `o_T` width is 1 cycle.
- No-adjust window: next ACQ begins at edge k+1; samples arriving in the DECIDE cycle are dropped.
- `o_locked` updates at the DECIDE exit edge only, except for clears by `i_en`/`i_restart`.

## Configuration

- `CDR_LOOP_STATS_EN` defined: adds outputs `o_nb_adj_early` [7:0] and `o_nb_adj_late` [7:0], saturating at 255. They increment on entry to ADJUST with `o_E`=0 and `o_E`=1 respectively, are reset to 0 by `i_rst` only, and are not cleared by `i_restart`.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Test plan

- 16 valid samples with 10 late and 2 early → `o_T`=1 and `o_E`=1 one cycle after DECIDE. Ack after 5 cycles → `o_T` low. The next 4 samples are ignored, then ACQ.
- 16 samples with 6 early and 3 late (difference 3 < 4) → no `o_T`. After 3 such windows, `o_locked`=1. A following window with 8 early and 0 late → `o_T`=1, `o_E`=0, `o_locked`=0.
- Request with no ack → `o_T` drops and `o_err` pulses exactly 255 cycles after `o_T` rose. A test where ack and timeout coincide → no `o_err`.
- Samples with early and late both asserted on all 16 → no votes counted, no adjust.
- `i_restart` while in ADJUST → `o_T`=0 on the next edge, counters cleared, `o_locked`=0. Assert `i_rst` low mid-window → every output is 0 asynchronously.
- With `CDR_LOOP_STATS_EN`: 300 early-dominant adjusts → `o_nb_adj_early`=255 and `o_nb_adj_late`=0.
